// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    // Responder control states: waiting, counting down the access, presenting a response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } imem_state_t;

    // Instruction word returned with an error response (wide enough for any DATA_W up to 64)
    localparam logic [63:0] IMEM_ERR_DATA = '0;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side request/response channel between the fetch stage and the responder.
interface imem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_responder_array.sv
// Instruction storage: asynchronous read port for fetches, synchronous write port for program loading.
module imem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data
);

    // Contents are deliberately not reset; the program image is loaded through the write port
    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_data = mem[rd_idx];

    // Load-port write; a read captured on the same edge still sees the old word
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction-memory responder with a valid/ready fetch channel,
// alignment/range error reporting and a write-only program load port.
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    imem_responder_if.slave   bus,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    imem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic              req_ready;
    logic              accept;
    logic              bad_fetch;
    logic [DATA_W-1:0] rd_data;

    // Only the word-index bits of the load address select a word; the rest are dropped on purpose
    logic              unused_ld_bits;
    assign unused_ld_bits = ^ld_addr;

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .rd_idx  (addr_q[IDX_W:1]),
        .rd_data (rd_data),
        .wr_en   (ld_en & rst),
        .wr_idx  (ld_addr[IDX_W:1]),
        .wr_data (ld_data)
    );

    // Misaligned PC or word index beyond the backing array
    assign bad_fetch = addr_q[0] | ({1'b0, addr_q[ADDR_W-1:1]} >= ADDR_W'(DEPTH));

    // Ready is combinational on rsp_ready so a consumed response can overlap the next accept
    assign req_ready = rst & ((state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready));
    assign accept    = bus.req_valid & req_ready;

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;

    // Next-state, latency countdown, address latch and response capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    addr_d  = bus.req_addr;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    err_d   = bad_fetch;
                    data_d  = bad_fetch ? DATA_W'(IMEM_ERR_DATA) : rd_data;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (accept) begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                        addr_d  = bus.req_addr;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset drops any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one LATENCY=2 instance and one LATENCY=1 instance
// sharing clock, reset and load port.
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;

    int checks = 0;
    int errors = 0;

    imem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();
    imem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

    imem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .LATENCY(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus2.slave),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    imem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus1.slave),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the bench ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Write one word through the shared load port
    task automatic load_word(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Issue one request on the LATENCY=2 instance, measure edges to rsp_valid, then consume it
    task automatic run_req2(input logic [15:0] addr, output int lat,
                            output logic [15:0] data, output logic err);
        @(negedge clk);
        bus2.req_valid = 1'b1;
        bus2.req_addr  = addr;
        bus2.rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        bus2.req_addr  = 16'hFFFF;
        lat = 0;
        while (!bus2.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        data = bus2.rsp_data;
        err  = bus2.rsp_err;
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        bus2.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus2.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0", bus2.req_ready); end
        checks++; if (bus2.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", bus2.rsp_valid); end
        checks++; if (bus2.rsp_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h expected 0000", bus2.rsp_data); end
        checks++; if (bus2.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", bus2.rsp_err); end
        rst = 1'b1;
        #1;
        checks++; if (bus2.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_req_ready: got %b expected 1", bus2.req_ready); end
        checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_req_ready_l1: got %b expected 1", bus1.req_ready); end
    endtask

    task automatic test_basic();
        int lat; logic [15:0] d; logic e;
        load_word(16'h000A, 16'hBEEF);
        run_req2(16'h000A, lat, d, e);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 2", lat); end
        checks++; if (d !== 16'hBEEF) begin errors++; $display("[TB] FAIL basic_data: got %h expected beef", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL basic_err: got %b expected 0", e); end
        checks++; if (bus2.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drop_valid: got %b expected 0", bus2.rsp_valid); end
    endtask

    task automatic test_errors();
        int lat; logic [15:0] d; logic e;
        run_req2(16'h0003, lat, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("[TB] FAIL misaligned_err: got %b expected 1", e); end
        checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL misaligned_data: got %h expected 0000", d); end
        run_req2(16'h0400, lat, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("[TB] FAIL range_err: got %b expected 1", e); end
        checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL range_data: got %h expected 0000", d); end
        load_word(16'h01FE, 16'h5A5A);
        run_req2(16'h01FE, lat, d, e);
        checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL last_word_err: got %b expected 0", e); end
        checks++; if (d !== 16'h5A5A) begin errors++; $display("[TB] FAIL last_word_data: got %h expected 5a5a", d); end
        run_req2(16'h0200, lat, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("[TB] FAIL first_oob_err: got %b expected 1", e); end
        checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL first_oob_data: got %h expected 0000", d); end
    endtask

    task automatic test_backpressure();
        int lat; logic [15:0] d; logic e;
        load_word(16'h000C, 16'hC0DE);
        @(negedge clk);
        bus2.req_valid = 1'b1;
        bus2.req_addr  = 16'h000C;
        bus2.rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus2.req_addr = 16'h000A;
        lat = 0;
        while (!bus2.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 2", lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus2.rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid[%0d]: got %b expected 1", i, bus2.rsp_valid); end
            checks++; if (bus2.rsp_data !== 16'hC0DE) begin errors++; $display("[TB] FAIL bp_hold_data[%0d]: got %h expected c0de", i, bus2.rsp_data); end
            checks++; if (bus2.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_ready[%0d]: got %b expected 0", i, bus2.req_ready); end
        end
        bus2.rsp_ready = 1'b1;
        #1;
        checks++; if (bus2.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %b expected 1", bus2.req_ready); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus2.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_gap_valid: got %b expected 0", bus2.rsp_valid); end
        bus2.req_valid = 1'b0;
        bus2.rsp_ready = 1'b0;
        lat = 0;
        while (!bus2.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d = bus2.rsp_data;
        e = bus2.rsp_err;
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL bp_next_latency: got %0d expected 2", lat); end
        checks++; if (d !== 16'hBEEF) begin errors++; $display("[TB] FAIL bp_next_data: got %h expected beef", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL bp_next_err: got %b expected 0", e); end
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        bus2.rsp_ready = 1'b0;
    endtask

    task automatic test_collision();
        int lat; logic [15:0] d; logic e;
        load_word(16'h0008, 16'hAAAA);
        @(negedge clk);
        bus2.req_valid = 1'b1;
        bus2.req_addr  = 16'h0008;
        bus2.rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 16'h0009;
        ld_data = 16'h1234;
        @(negedge clk);
        ld_en = 1'b0;
        checks++; if (bus2.rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL collide_valid: got %b expected 1", bus2.rsp_valid); end
        checks++; if (bus2.rsp_data !== 16'hAAAA) begin errors++; $display("[TB] FAIL collide_old_data: got %h expected aaaa", bus2.rsp_data); end
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        bus2.rsp_ready = 1'b0;
        run_req2(16'h0008, lat, d, e);
        checks++; if (d !== 16'h1234) begin errors++; $display("[TB] FAIL collide_reread: got %h expected 1234", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL collide_reread_err: got %b expected 0", e); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus2.req_valid = 1'b1;
        bus2.req_addr  = 16'h000A;
        @(posedge clk);
        #3;
        bus2.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (bus2.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_req_ready: got %b expected 0", bus2.req_ready); end
        checks++; if (bus2.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rsp_valid: got %b expected 0", bus2.rsp_valid); end
        checks++; if (bus2.rsp_data !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_rsp_data: got %h expected 0000", bus2.rsp_data); end
        checks++; if (bus2.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rsp_err: got %b expected 0", bus2.rsp_err); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus2.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_release_ready: got %b expected 1", bus2.req_ready); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (bus2.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stale_valid[%0d]: got %b expected 0", i, bus2.rsp_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_data [3];
        exp_data[0] = 16'h1111;
        exp_data[1] = 16'h2222;
        exp_data[2] = 16'h3333;
        load_word(16'h0000, 16'h1111);
        load_word(16'h0002, 16'h2222);
        load_word(16'h0004, 16'h3333);
        @(negedge clk);
        bus1.req_valid = 1'b1;
        bus1.req_addr  = 16'h0000;
        bus1.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus1.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL l1_busy_valid[%0d]: got %b expected 0", i, bus1.rsp_valid); end
            bus1.req_addr = 16'((i + 1) * 2);
            if (i == 2) bus1.req_valid = 1'b0;
            @(negedge clk);
            checks++; if (bus1.rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL l1_rsp_valid[%0d]: got %b expected 1", i, bus1.rsp_valid); end
            checks++; if (bus1.rsp_data !== exp_data[i]) begin errors++; $display("[TB] FAIL l1_rsp_data[%0d]: got %h expected %h", i, bus1.rsp_data, exp_data[i]); end
            checks++; if (bus1.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL l1_rsp_err[%0d]: got %b expected 0", i, bus1.rsp_err); end
        end
        @(negedge clk);
        checks++; if (bus1.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL l1_final_idle: got %b expected 0", bus1.rsp_valid); end
        bus1.rsp_ready = 1'b0;
    endtask

    // Run every scenario in order, then report
    initial begin
        rst            = 1'b0;
        ld_en          = 1'b0;
        ld_addr        = '0;
        ld_data        = '0;
        bus2.req_valid = 1'b0;
        bus2.req_addr  = '0;
        bus2.rsp_ready = 1'b0;
        bus1.req_valid = 1'b0;
        bus1.req_addr  = '0;
        bus1.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_errors();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
